spi_mnrch: RTL

- 16-bit SPI master (mode 3: SCLK idles high; the slave samples on SCLK rise; both sides shift on SCLK fall) sitting directly downstream of inert_intf.
- inert_intf issues wrt/wt_data to configure the iNEMO gyro and read yaw registers, then consumes done/rd_data.
- Drives SS_n/SCLK/MOSI to the sensor and samples MISO.
- One full-duplex transaction per wrt.

---
 rtl/spi_pkg.sv | 24 ++
 rtl/spi_mnrch.sv | 99 +++++++++
 2 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the iNEMO SPI master (spi_mnrch) and the
// inert_intf command issuer that drives it.
package spi_pkg;

  typedef enum logic {IDLE, ACTIVE} spi_state_t;

  localparam int DATA_W_DEF = 16;
  localparam int DIV_W_DEF  = 5;

  // Divider preload: the first SCLK fall lands a quarter period after start.
  function automatic int div_load(input int div_w);
    return 2**(div_w-1) + 2**(div_w-2) - 1;
  endfunction

  localparam logic [DIV_W_DEF-1:0] DIV_LOAD = DIV_W_DEF'(div_load(DIV_W_DEF));

  localparam logic [15:0] READ_FLAG = 16'h8000;
  localparam logic [7:0]  WHO_AM_I  = 8'h0F;
  localparam logic [7:0]  INT1_CTRL = 8'h0D;
  localparam logic [7:0]  CTRL2_G   = 8'h11;
  localparam logic [7:0]  OUTZ_L    = 8'h26;
  localparam logic [7:0]  OUTZ_H    = 8'h27;

endpackage

// File: rtl/spi_mnrch.sv
// Mode-3 SPI master: one full-duplex DATA_W-bit transfer per wrt strobe,
// MSB first, SCLK derived from the top bit of a free-running divider.
module spi_mnrch
  import spi_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DIV_W  = DIV_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrt,
  input  logic [DATA_W-1:0] wt_data,
  input  logic              MISO,
  output logic              SS_n,
  output logic              SCLK,
  output logic              MOSI,
  output logic              done,
  output logic [DATA_W-1:0] rd_data
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [DIV_W-1:0] LOAD     = DIV_W'(div_load(DIV_W));
  localparam logic [DIV_W-1:0] SMPL_AT  = DIV_W'(2**(DIV_W-1) - 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W);

  spi_state_t state, state_nxt;

  logic [DIV_W-1:0]  div;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shft_reg;
  logic              miso_smpl;
  logic              accept, smpl, shft, finish;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Sample fires the clk before SCLK rises; shift coincides with SCLK falling,
  // except the very first fall which only opens the transfer.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    smpl      = 1'b0;
    shft      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (wrt) begin
          accept    = 1'b1;
          state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        smpl = (div == SMPL_AT);
        shft = (div == '1) && (bit_cnt != '0);
        if (shft && (bit_cnt == LAST_BIT)) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div       <= '0;
      bit_cnt   <= '0;
      shft_reg  <= '0;
      miso_smpl <= 1'b0;
      SS_n      <= 1'b1;
      done      <= 1'b0;
    end else if (accept) begin
      shft_reg <= wt_data;
      div      <= LOAD;
      bit_cnt  <= '0;
      SS_n     <= 1'b0;
      done     <= 1'b0;
    end else if (state == ACTIVE) begin
      div <= div + 1'b1;
      if (smpl) begin
        miso_smpl <= MISO;
        bit_cnt   <= bit_cnt + 1'b1;
      end
      if (shft) shft_reg <= {shft_reg[DATA_W-2:0], miso_smpl};
      if (finish) begin
        SS_n <= 1'b1;
        done <= 1'b1;
      end
    end
  end

  // SCLK is held high outside a transfer so the final divider wrap makes no edge.
  assign SCLK    = (state == ACTIVE) ? div[DIV_W-1] : 1'b1;
  assign MOSI    = shft_reg[DATA_W-1];
  assign rd_data = shft_reg;

endmodule
